// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, press/release debounce,
// debounced level, long-press detect and optional auto-repeat per channel.
module key_debounce_multi #(
  parameter int NUM_KEYS      = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 20000,
  parameter int LONG_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);

  // state     | meaning
  // IDLE      | key released, waiting for an active sample
  // PRESS_CHK | active samples seen, counting towards press acceptance
  // HELD      | press accepted, timing long-press / auto-repeat
  // REL_CHK   | inactive samples seen while held, counting towards release
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam int MAX_AB = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic          INACTIVE  = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DEB_TC    = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0] press_nx;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic          ff1, ff2, act;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    assign act = (ACTIVE_LOW != 0) ? ~ff2 : ff2;

    always_ff @(posedge clk) begin
      if (rst) begin
        ff1         <= INACTIVE;
        ff2         <= INACTIVE;
        state_q     <= IDLE;
        cnt_q       <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        ff1         <= key_in[g];
        ff2         <= ff1;
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (act) state_d = PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!act) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_TC) begin
            state_d     = HELD;
            cnt_d       = '0;
            press_d     = 1'b1;
            level_d     = 1'b1;
            long_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!act) begin
            state_d = REL_CHK;
            cnt_d   = '0;
          end else if (!long_done_q && cnt_q == LONG_TC) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            cnt_d       = '0;
          end else if (long_done_q && repeat_en && cnt_q == REPEAT_TC) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else if (long_done_q && !repeat_en) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        REL_CHK: begin
          // a bounce back to active keeps long_done so key_long cannot re-fire
          if (act) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEB_TC) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign press_nx[g]    = press_d;
    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
    assign key_repeat[g]  = repeat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) key_any <= 1'b0;
    else     key_any <= |press_nx;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: directed scenarios plus random key
// activity, checked against a run-length reference model of the debouncer.
module tb_key_debounce_multi;
  localparam int NK     = 4;
  localparam int DEB    = 8;
  localparam int LONG   = 32;
  localparam int REPEAT = 10;

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
    logic [NK-1:0] rpt;
    logic          any;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic          repeat_en = 1'b0;
  logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;
  logic          key_any;

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat), .key_any(key_any)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model: a level flips after DEB+1 consecutive synchronised samples
  // that disagree with it; held time counts agreeing samples since the press or
  // since the sample that ended a release bounce.
  logic [NK-1:0] h1 = '1, h2 = '1;
  logic [NK-1:0] m_lvl = '0, m_ld = '0, m_gl = '0;
  int            m_run[NK];
  int            m_held[NK];

  task automatic model_step(input logic [NK-1:0] p, input logic ren_i, input logic r,
                            output exp_t e);
    logic [NK-1:0] actv;
    e = '0;
    if (r) begin
      h1 = '1; h2 = '1;
      m_lvl = '0; m_ld = '0; m_gl = '0;
      for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      actv = ~h2;
      for (int i = 0; i < NK; i++) begin
        if (!m_lvl[i]) begin
          if (actv[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
              m_lvl[i] = 1'b1; e.prs[i] = 1'b1; m_run[i] = 0;
              m_held[i] = 0; m_ld[i] = 1'b0; m_gl[i] = 1'b0;
            end
          end else m_run[i] = 0;
        end else if (!actv[i]) begin
          m_run[i]++;
          m_gl[i] = 1'b1;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i] = 1'b0; e.rel[i] = 1'b1; m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
          if (m_gl[i]) begin
            m_gl[i] = 1'b0; m_held[i] = 0;
          end else if (!m_ld[i]) begin
            m_held[i]++;
            if (m_held[i] == LONG) begin e.lng[i] = 1'b1; m_ld[i] = 1'b1; m_held[i] = 0; end
          end else if (ren_i) begin
            m_held[i]++;
            if (m_held[i] == REPEAT) begin e.rpt[i] = 1'b1; m_held[i] = 0; end
          end
        end
      end
      h2 = h1; h1 = p;
      e.lvl = m_lvl;
      e.any = |e.prs;
    end
  endtask

  // drive one clock's inputs, queue the model's response, advance to next negedge
  task automatic cyc(input logic r);
    exp_t e;
    rst = r;
    model_step(key_in, repeat_en, r, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({key_level, key_press, key_release, key_long, key_repeat, key_any} !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b lng=%b rpt=%b any=%b want lvl=%b prs=%b rel=%b lng=%b rpt=%b any=%b",
                   $time, key_level, key_press, key_release, key_long, key_repeat, key_any,
                   e.lvl, e.prs, e.rel, e.lng, e.rpt, e.any);
        end
      end
    end
  end

  initial begin : driver
    int first_press;
    int hold[NK];
    @(negedge clk);
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    run_n(3);

    // 1: ch0 held 40 cycles, no repeat; press latency checked directly too
    key_in[0] = 1'b0;
    first_press = -1;
    for (int n = 1; n <= 40; n++) begin
      cyc(1'b0);
      if (key_press[0] && key_any && first_press < 0) first_press = n;
    end
    checks++;
    if (first_press != DEB + 3) begin
      failures++;
      $display("FAIL press_latency got edge %0d want edge %0d", first_press, DEB + 3);
    end
    key_in[0] = 1'b1;
    run_n(15);

    // 2: ch1 bounce then stable press
    for (int b = 0; b < 3; b++) begin
      key_in[1] = 1'b0; run_n(5);
      key_in[1] = 1'b1; run_n(1);
    end
    key_in[1] = 1'b0; run_n(20);
    key_in[1] = 1'b1; run_n(15);

    // 3: ch2 long press with auto-repeat
    repeat_en = 1'b1;
    key_in[2] = 1'b0; run_n(100);
    key_in[2] = 1'b1; run_n(15);

    // 4: ch2 long press, no repeat, one-cycle release glitch after key_long
    repeat_en = 1'b0;
    key_in[2] = 1'b0; run_n(50);
    key_in[2] = 1'b1; run_n(1);
    key_in[2] = 1'b0; run_n(20);
    repeat_en = 1'b1; run_n(25);
    key_in[2] = 1'b1; run_n(15);

    // 5: ch0 and ch3 on the same edge
    key_in[0] = 1'b0; key_in[3] = 1'b0; run_n(15);
    key_in[0] = 1'b1; key_in[3] = 1'b1; run_n(15);

    // 6: reset while ch0 held, key stays down afterwards
    key_in[0] = 1'b0; run_n(20);
    cyc(1'b1);
    run_n(20);
    key_in[0] = 1'b1; run_n(15);

    // random activity on all channels
    for (int i = 0; i < NK; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key_in[i] = ~key_in[i];
          hold[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12))
                                                 : int'($urandom_range(10, 70));
        end else hold[i]--;
      end
      if ($urandom_range(0, 49) == 0) repeat_en = ~repeat_en;
      cyc($urandom_range(0, 499) == 0);
    end

    key_in = '1;
    run_n(20);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
